// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one-outstanding imem requests
// and feeds the IF/ID register through a one-entry skid buffer under stall.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        HOLD
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] START_PC   = RESET_PC & ALIGN_MASK;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] inflight_pc;
    logic [31:0] inflight_pc_next;
    logic        deliver;
    logic        to_skid;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    assign imem_req  = (state == REQ);
    assign imem_addr = fetch_pc;

    // A delivery lands in the skid only when the IF/ID register is occupied and held.
    assign to_skid = id_valid && stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        inflight_pc_next = inflight_pc;
        deliver          = 1'b0;

        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (imem_gnt) begin
                    inflight_pc_next = fetch_pc;
                    fetch_pc_next    = fetch_pc + 32'd4;
                    state_next       = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_next = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    deliver    = 1'b1;
                    state_next = to_skid ? HOLD : REQ;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_next = REQ;
                end
            end
            HOLD: begin
                if (redirect || (!stall && skid_valid)) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A redirect target always wins over the sequential increment.
        if (redirect) begin
            fetch_pc_next = redirect_pc & ALIGN_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= START_PC;
            inflight_pc <= START_PC;
        end else begin
            fetch_pc    <= fetch_pc_next;
            inflight_pc <= inflight_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            id_valid   <= 1'b0;
            id_pc      <= RESET_PC;
            id_instr   <= NOP_INSTR;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (redirect) begin
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (deliver) begin
            if (!to_skid) begin
                id_valid <= 1'b1;
                id_pc    <= inflight_pc;
                id_instr <= imem_rdata;
            end else begin
                skid_valid <= 1'b1;
                skid_pc    <= inflight_pc;
                skid_instr <= imem_rdata;
            end
        end else if (!stall) begin
            if (skid_valid) begin
                id_valid   <= 1'b1;
                id_pc      <= skid_pc;
                id_instr   <= skid_instr;
                skid_valid <= 1'b0;
            end else begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
        end
    end

endmodule
